// File: rtl/isp_route_ctrl.sv
// ---------------------------------------------------------------------------
// isp_route_ctrl
//
// Frame-synchronous router for the ISP chain. A per-stage enable mask picks
// which stages sit in the video path. Enabled stages are chained in index
// order. Disabled stages are bypassed and have their inputs held at zero.
// The mask is only swapped at a frame start (rising edge of src_vs). After a
// swap, a guard counter blanks the sink for MAXL cycles while pixels that
// were routed under the old mask drain out. sink_vs is the source vsync
// delayed by the latency of the path that is currently active.
//
// Streaming semantics: this is a pure push interface. A beat moves whenever
// its *_de is high. There is no ready/backpressure in either direction, and
// stage outputs are taken as they arrive, without any latency check.
//
// Ports
//   clk, rst_n     pixel clock, asynchronous active-low reset
//   cfg_mask       requested stage enable mask (bit i enables stage i)
//   src_data/de/vs Bayer source pixel, data enable, vsync
//   st_out_data/de stage outputs (stage i at [i*DW +: DW])
//   st_in_data/de  stage inputs (registered, zero when stage disabled)
//   sink_data/de   routed pixel to HDMI (blanked while guard runs)
//   sink_vs        vsync delayed to match the active path latency
//   active_mask    mask currently in force
//   cfg_busy       requested mask differs from active mask, or guard running
// ---------------------------------------------------------------------------
module isp_route_ctrl #(
    parameter int              DW       = 24,
    parameter int              NS       = 4,
    parameter int              STG_LAT  = 2,
    parameter logic [NS-1:0]   RST_MASK = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NS-1:0]      cfg_mask,
    input  logic [DW-1:0]      src_data,
    input  logic               src_de,
    input  logic               src_vs,
    input  logic [NS*DW-1:0]   st_out_data,
    input  logic [NS-1:0]      st_out_de,
    output logic [NS*DW-1:0]   st_in_data,
    output logic [NS-1:0]      st_in_de,
    output logic [DW-1:0]      sink_data,
    output logic               sink_de,
    output logic               sink_vs,
    output logic [NS-1:0]      active_mask,
    output logic               cfg_busy
);

    // Worst-case path: every stage enabled, one register hop in front of each
    // stage plus the sink register.
    localparam int MAXL = NS * (STG_LAT + 1) + 1;
    localparam int GW   = $clog2(MAXL + 1);
    localparam int TW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    logic               src_vs_q;
    logic [NS-1:0]      mask_q,       mask_d;
    logic [GW-1:0]      guard_q,      guard_d;
    logic [MAXL-1:0]    vs_dly_q;
    logic [NS*DW-1:0]   st_in_data_q, st_in_data_d;
    logic [NS-1:0]      st_in_de_q,   st_in_de_d;
    logic [DW-1:0]      sink_data_q,  sink_data_d;
    logic               sink_de_q,    sink_de_d;

    logic               fs;
    logic               mask_chg;
    logic               guard_on;
    logic [DW-1:0]      feed_data;
    logic               feed_de;
    int                 n_en;
    logic [TW-1:0]      tap_idx;

    assign fs       = src_vs & ~src_vs_q;
    assign mask_chg = (cfg_mask != mask_q);
    assign guard_on = (guard_q != '0);

    // Mask and guard update. A frame start with an unchanged mask leaves the
    // guard counting down normally; only a real change (re)loads it.
    always_comb begin
        mask_d  = mask_q;
        guard_d = guard_on ? (guard_q - GW'(1)) : '0;
        if (fs) begin
            mask_d = cfg_mask;
            if (mask_chg) begin
                guard_d = GW'(MAXL);
            end
        end
    end

    // Routing: walk the chain in index order. feed_* always holds the output
    // of the highest enabled stage seen so far (or the source if none). Each
    // enabled stage takes the current feed and then becomes the new feed.
    // Whatever is left at the end goes to the sink.
    always_comb begin
        st_in_data_d = '0;
        st_in_de_d   = '0;
        feed_data    = src_data;
        feed_de      = src_de;
        for (int i = 0; i < NS; i++) begin
            if (mask_q[i]) begin
                st_in_data_d[i*DW +: DW] = feed_data;
                st_in_de_d[i]            = feed_de;
                feed_data                = st_out_data[i*DW +: DW];
                feed_de                  = st_out_de[i];
            end
        end
        sink_data_d = feed_data;
        sink_de_d   = feed_de;
    end

    // Path latency is (k+1) + k*STG_LAT for k enabled stages. Tap index is
    // latency-1 because vs_dly_q[0] is already one cycle behind src_vs.
    always_comb begin
        n_en = 0;
        for (int i = 0; i < NS; i++) begin
            if (mask_q[i]) begin
                n_en = n_en + 1;
            end
        end
        tap_idx = TW'(n_en * (STG_LAT + 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_vs_q     <= 1'b0;
            mask_q       <= RST_MASK;
            guard_q      <= '0;
            vs_dly_q     <= '0;
            st_in_data_q <= '0;
            st_in_de_q   <= '0;
            sink_data_q  <= '0;
            sink_de_q    <= 1'b0;
        end else begin
            src_vs_q     <= src_vs;
            mask_q       <= mask_d;
            guard_q      <= guard_d;
            vs_dly_q     <= {vs_dly_q[MAXL-2:0], src_vs};
            st_in_data_q <= st_in_data_d;
            st_in_de_q   <= st_in_de_d;
            sink_data_q  <= sink_data_d;
            sink_de_q    <= sink_de_d;
        end
    end

    assign st_in_data  = st_in_data_q;
    assign st_in_de    = st_in_de_q;
    // Mixed old/new-path pixels are hidden while the guard runs. vsync is
    // left untouched so the sink keeps frame timing.
    assign sink_data   = guard_on ? '0 : sink_data_q;
    assign sink_de     = guard_on ? 1'b0 : sink_de_q;
    assign sink_vs     = vs_dly_q[tap_idx];
    assign active_mask = mask_q;
    assign cfg_busy    = mask_chg | guard_on;

endmodule

// File: tb/tb_isp_route_ctrl.sv
// ---------------------------------------------------------------------------
// tb_isp_route_ctrl
//
// Stages are modelled as a 2-cycle delay that adds 1 to the data. The
// reference model keeps a per-edge history of source inputs and derives the
// expected sink and stage inputs from the path latency and the number of
// enabled stages in front of each point.
// ---------------------------------------------------------------------------
module tb_isp_route_ctrl;
  localparam int DW       = 24;
  localparam int NS       = 4;
  localparam int STG_LAT  = 2;
  localparam int MAXL     = NS * (STG_LAT + 1) + 1;
  localparam int HN       = 4096;
  localparam logic [NS-1:0] RST_MASK = '0;

  logic              clk;
  logic              rst_n;
  logic [NS-1:0]     cfg_mask;
  logic [DW-1:0]     src_data;
  logic              src_de;
  logic              src_vs;
  logic [NS*DW-1:0]  st_out_data;
  logic [NS-1:0]     st_out_de;
  logic [NS*DW-1:0]  st_in_data;
  logic [NS-1:0]     st_in_de;
  logic [DW-1:0]     sink_data;
  logic              sink_de;
  logic              sink_vs;
  logic [NS-1:0]     active_mask;
  logic              cfg_busy;

  int checks;
  int errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  isp_route_ctrl #(
    .DW(DW), .NS(NS), .STG_LAT(STG_LAT), .RST_MASK(RST_MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mask(cfg_mask),
    .src_data(src_data), .src_de(src_de), .src_vs(src_vs),
    .st_out_data(st_out_data), .st_out_de(st_out_de),
    .st_in_data(st_in_data), .st_in_de(st_in_de),
    .sink_data(sink_data), .sink_de(sink_de), .sink_vs(sink_vs),
    .active_mask(active_mask), .cfg_busy(cfg_busy)
  );

  // ---------------- stage models: 2-cycle delay, data + 1 ----------------
  logic [NS*DW-1:0] stg_d1, stg_d2;
  logic [NS-1:0]    stg_de1, stg_de2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_d1  <= '0;
      stg_d2  <= '0;
      stg_de1 <= '0;
      stg_de2 <= '0;
    end else begin
      for (int i = 0; i < NS; i++) stg_d1[i*DW +: DW] <= st_in_data[i*DW +: DW] + DW'(1);
      stg_d2  <= stg_d1;
      stg_de1 <= st_in_de;
      stg_de2 <= stg_de1;
    end
  end
  assign st_out_data = stg_d2;
  assign st_out_de   = stg_de2;

  // ---------------- reference model ----------------
  int             ecnt;
  int             rst_ecnt;
  int             m_guard;
  logic [NS-1:0]  m_mask;
  logic [NS-1:0]  m_mask_prev;
  logic           m_pv;
  logic           hv  [HN];
  logic           hde [HN];
  logic [DW-1:0]  hd  [HN];

  function automatic int lat_of(input logic [NS-1:0] m);
    return $countones(m) * (STG_LAT + 1) + 1;
  endfunction

  task automatic model_reset();
    m_mask      = RST_MASK;
    m_mask_prev = RST_MASK;
    m_guard     = 0;
    m_pv        = 1'b0;
    rst_ecnt    = ecnt + 1;
  endtask

  // One clock edge: record the inputs that the edge samples, advance the
  // model, then step 1 time unit past the edge for sampling.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      ecnt++;
      hv[ecnt % HN]  = src_vs;
      hde[ecnt % HN] = src_de;
      hd[ecnt % HN]  = src_data;
      m_mask_prev    = m_mask;
      if (src_vs && !m_pv) begin
        if (cfg_mask != m_mask) m_guard = MAXL;
        else if (m_guard > 0)   m_guard--;
        m_mask = cfg_mask;
      end else if (m_guard > 0) begin
        m_guard--;
      end
      m_pv = src_vs;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; cfg_mask = '0; src_data = '0; src_de = 1'b0; src_vs = 1'b0;
    model_reset();
    tick(); tick();
    checks++; if (sink_de !== 1'b0) begin errors++; $display("FAIL reset_sink_de got=%0h exp=0", sink_de); end
    checks++; if (sink_data !== '0) begin errors++; $display("FAIL reset_sink_data got=%0h exp=0", sink_data); end
    checks++; if (sink_vs !== 1'b0) begin errors++; $display("FAIL reset_sink_vs got=%0h exp=0", sink_vs); end
    checks++; if (st_in_de !== '0) begin errors++; $display("FAIL reset_st_in_de got=%0h exp=0", st_in_de); end
    checks++; if (st_in_data !== '0) begin errors++; $display("FAIL reset_st_in_data got=%0h exp=0", st_in_data); end
    checks++; if (active_mask !== RST_MASK) begin errors++; $display("FAIL reset_active_mask got=%0h exp=%0h", active_mask, RST_MASK); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy got=%0h exp=0", cfg_busy); end
    cfg_mask = 4'b0101;
    #1;
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_req got=%0h exp=1", cfg_busy); end
    cfg_mask = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    src_de = 1'b1; src_data = 24'h123456;
    tick();
    src_de = 1'b0; src_data = '0;
    checks++; if (sink_de !== 1'b1) begin errors++; $display("FAIL bypass_de got=%0h exp=1", sink_de); end
    checks++; if (sink_data !== 24'h123456) begin errors++; $display("FAIL bypass_data got=%0h exp=123456", sink_data); end
    checks++; if (st_in_de !== '0) begin errors++; $display("FAIL bypass_st_in_de got=%0h exp=0", st_in_de); end
    tick();
    checks++; if (sink_de !== 1'b0) begin errors++; $display("FAIL bypass_de_end got=%0h exp=0", sink_de); end
    checks++; if (st_in_de !== '0) begin errors++; $display("FAIL bypass_st_in_de_end got=%0h exp=0", st_in_de); end
  endtask

  task automatic test_midframe_cfg();
    int n;
    src_vs = 1'b1; tick(); tick();
    src_vs = 1'b0; tick(); tick(); tick();
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_idle got=%0h exp=0", cfg_busy); end
    cfg_mask = 4'b0011;
    tick(); tick(); tick();
    checks++; if (active_mask !== 4'b0000) begin errors++; $display("FAIL mid_active_hold got=%0h exp=0", active_mask); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pending got=%0h exp=1", cfg_busy); end
    src_de = 1'b1; src_data = 24'hABCDEF; src_vs = 1'b1;
    tick();
    src_vs = 1'b0;
    checks++; if (active_mask !== 4'b0011) begin errors++; $display("FAIL mid_active_load got=%0h exp=3", active_mask); end
    n = 0;
    while (sink_de === 1'b0 && n < 30) begin n++; tick(); end
    checks++; if (n != MAXL) begin errors++; $display("FAIL mid_blank_len got=%0d exp=%0d", n, MAXL); end
    checks++; if (sink_data !== 24'hABCDF1) begin errors++; $display("FAIL mid_data_after got=%0h exp=abcdf1", sink_data); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_done got=%0h exp=0", cfg_busy); end
    src_de = 1'b0;
  endtask

  // Drain, then frame start with new_mask; measure vsync delay and blanking.
  task automatic test_switch(input logic [NS-1:0] new_mask, input int exp_delay, input int exp_blank);
    int first_vs;
    int blank;
    src_de = 1'b1; src_vs = 1'b0;
    for (int i = 0; i < MAXL + 2; i++) begin src_data = DW'($urandom); tick(); end
    cfg_mask = new_mask; src_vs = 1'b1;
    first_vs = -1; blank = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      src_vs = 1'b0;
      if (sink_vs === 1'b1 && first_vs < 0) first_vs = n;
      if (sink_de !== 1'b1) blank++;
    end
    checks++; if (first_vs != exp_delay) begin errors++; $display("FAIL switch_%0h_vs_delay got=%0d exp=%0d", new_mask, first_vs, exp_delay); end
    checks++; if (blank != exp_blank) begin errors++; $display("FAIL switch_%0h_blank got=%0d exp=%0d", new_mask, blank, exp_blank); end
    checks++; if (active_mask !== new_mask) begin errors++; $display("FAIL switch_%0h_active got=%0h exp=%0h", new_mask, active_mask, new_mask); end
  endtask

  // Mask 1010: source -> stage1 -> stage3 -> sink, stages 0/2 idle.
  task automatic test_mask_1010();
    logic [DW-1:0] s1, s3;
    src_de = 1'b0; src_data = '0; src_vs = 1'b0;
    for (int i = 0; i < MAXL + 2; i++) tick();
    src_de = 1'b1; src_data = 24'h000020;
    for (int n = 1; n <= 9; n++) begin
      tick();
      src_de = 1'b0; src_data = '0;
      s1 = st_in_data[1*DW +: DW];
      s3 = st_in_data[3*DW +: DW];
      checks++; if ({st_in_de[2], st_in_de[0]} !== 2'b00) begin errors++; $display("FAIL m1010_idle_de n=%0d got=%0h exp=0", n, {st_in_de[2], st_in_de[0]}); end
      checks++; if ({st_in_data[2*DW +: DW], st_in_data[0 +: DW]} !== '0) begin errors++; $display("FAIL m1010_idle_data n=%0d got=%0h exp=0", n, {st_in_data[2*DW +: DW], st_in_data[0 +: DW]}); end
      checks++; if (st_in_de[1] !== (n == 1)) begin errors++; $display("FAIL m1010_s1_de n=%0d got=%0h", n, st_in_de[1]); end
      checks++; if (st_in_de[3] !== (n == 4)) begin errors++; $display("FAIL m1010_s3_de n=%0d got=%0h", n, st_in_de[3]); end
      checks++; if (sink_de !== (n == 7)) begin errors++; $display("FAIL m1010_sink_de n=%0d got=%0h", n, sink_de); end
      if (n == 1) begin checks++; if (s1 !== 24'h20) begin errors++; $display("FAIL m1010_s1_data got=%0h exp=20", s1); end end
      if (n == 4) begin checks++; if (s3 !== 24'h21) begin errors++; $display("FAIL m1010_s3_data got=%0h exp=21", s3); end end
      if (n == 7) begin checks++; if (sink_data !== 24'h22) begin errors++; $display("FAIL m1010_sink_data got=%0h exp=22", sink_data); end end
    end
  endtask

  task automatic test_random_traffic(input int ncyc);
    int idx, nb, sidx;
    logic          exp_vs, exp_busy;
    logic [DW-1:0] exp_d;
    for (int c = 0; c < ncyc; c++) begin
      src_vs   = ((c % 40) < 2);
      src_de   = ($urandom_range(0, 1) == 1);
      src_data = DW'($urandom);
      if ($urandom_range(0, 24) == 0) cfg_mask = NS'($urandom_range(0, 15));
      tick();
      checks++; if (active_mask !== m_mask) begin errors++; $display("FAIL rnd_active c=%0d got=%0h exp=%0h", c, active_mask, m_mask); end
      exp_busy = (cfg_mask != m_mask) || (m_guard != 0);
      checks++; if (cfg_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy c=%0d got=%0h exp=%0h", c, cfg_busy, exp_busy); end
      idx    = ecnt - lat_of(m_mask) + 1;
      exp_vs = (idx >= rst_ecnt) ? hv[idx % HN] : 1'b0;
      checks++; if (sink_vs !== exp_vs) begin errors++; $display("FAIL rnd_sink_vs c=%0d got=%0h exp=%0h", c, sink_vs, exp_vs); end
      if (m_guard != 0) begin
        checks++; if (sink_de !== 1'b0 || sink_data !== '0) begin errors++; $display("FAIL rnd_blank c=%0d got=%0h/%0h exp=0/0", c, sink_de, sink_data); end
      end else if (idx >= rst_ecnt) begin
        exp_d = hd[idx % HN] + DW'($countones(m_mask));
        checks++; if (sink_de !== hde[idx % HN]) begin errors++; $display("FAIL rnd_sink_de c=%0d got=%0h exp=%0h", c, sink_de, hde[idx % HN]); end
        checks++; if (sink_data !== exp_d) begin errors++; $display("FAIL rnd_sink_data c=%0d got=%0h exp=%0h", c, sink_data, exp_d); end
      end
      for (int i = 0; i < NS; i++) begin
        if (!m_mask_prev[i]) begin
          checks++; if (st_in_de[i] !== 1'b0 || st_in_data[i*DW +: DW] !== '0) begin errors++; $display("FAIL rnd_idle_stage%0d c=%0d got=%0h/%0h exp=0/0", i, c, st_in_de[i], st_in_data[i*DW +: DW]); end
        end else if (m_guard == 0) begin
          nb   = 0;
          for (int j = 0; j < i; j++) if (m_mask[j]) nb++;
          sidx = ecnt - nb * (STG_LAT + 1);
          if (sidx >= rst_ecnt) begin
            exp_d = hd[sidx % HN] + DW'(nb);
            checks++; if (st_in_de[i] !== hde[sidx % HN] || st_in_data[i*DW +: DW] !== exp_d) begin errors++; $display("FAIL rnd_stage%0d_in c=%0d got=%0h/%0h exp=%0h/%0h", i, c, st_in_de[i], st_in_data[i*DW +: DW], hde[sidx % HN], exp_d); end
          end
        end
      end
    end
    src_vs = 1'b0;
  endtask

  task automatic test_async_reset();
    test_switch(4'b1111, 13, 13);
    for (int i = 0; i < 7; i++) begin
      src_de = ($urandom_range(0, 1) == 1); src_data = DW'($urandom); tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (sink_de !== 1'b0 || sink_data !== '0 || sink_vs !== 1'b0) begin errors++; $display("FAIL arst_sink got=%0h/%0h/%0h exp=0/0/0", sink_de, sink_data, sink_vs); end
    checks++; if (st_in_de !== '0 || st_in_data !== '0) begin errors++; $display("FAIL arst_st_in got=%0h/%0h exp=0/0", st_in_de, st_in_data); end
    checks++; if (active_mask !== RST_MASK) begin errors++; $display("FAIL arst_active got=%0h exp=%0h", active_mask, RST_MASK); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL arst_busy got=%0h exp=1", cfg_busy); end
    src_de = 1'b0; src_vs = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (active_mask !== RST_MASK) begin errors++; $display("FAIL arst_hold got=%0h exp=%0h", active_mask, RST_MASK); end
    src_vs = 1'b1;
    tick();
    src_vs = 1'b0;
    checks++; if (active_mask !== 4'b1111) begin errors++; $display("FAIL arst_first_fs got=%0h exp=f", active_mask); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL arst_guard_busy got=%0h exp=1", cfg_busy); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks = 0; errors = 0; ecnt = 0; rst_ecnt = 0;
    test_reset();
    test_bypass();
    test_midframe_cfg();
    test_switch(4'b0011, 7, 0);
    test_switch(4'b1111, 13, 13);
    test_switch(4'b1111, 13, 0);
    test_switch(4'b0000, 1, 13);
    test_switch(4'b1010, 7, 13);
    test_mask_1010();
    test_random_traffic(800);
    test_async_reset();
    test_random_traffic(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
